// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: arbitration mode and packet-lock state types shared by stream_mux
package stream_mux_pkg;
  typedef enum logic {MODE_RR, MODE_SEL} mode_e;
  typedef enum logic {ST_IDLE, ST_LOCKED} lock_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational one-hot round-robin grant, lowest requester at or after ptr wins
module rr_arbiter #(
  parameter int N_CH = 4,
  localparam int SW = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [SW-1:0]   ptr,
  output logic [N_CH-1:0] gnt
);
  logic [SW-1:0] j;
  always_comb begin
    gnt = '0;
    j = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      j = SW'((int'(ptr) + k) % N_CH);
      if (req[j]) gnt = N_CH'(1) << j;
    end
  end
endmodule

// File: rtl/stream_mux.sv
// stream_mux: N-channel valid/ready mux with registered output, RR or manual select
// STREAM_MUX_PKT_LOCK_EN holds the grant on one channel until its in_last beat
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DW = 8,
  localparam int SW = $clog2(N_CH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SW-1:0]      sel,
  input  logic [N_CH-1:0]    in_valid,
  input  logic [N_CH*DW-1:0] in_data,
  input  logic [N_CH-1:0]    in_last,
  output logic [N_CH-1:0]    in_ready,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic               out_last,
  output logic [SW-1:0]      out_ch,
  input  logic               out_ready
);
  logic ld, xfer, locked, adv;
  logic [SW-1:0] ptr, gidx, lock_ch;
  logic [N_CH-1:0] rr_gnt, grant, lock_gnt;
  rr_arbiter #(.N_CH(N_CH)) u_rr (.req(in_valid), .ptr(ptr), .gnt(rr_gnt));
  assign ld = !out_valid || out_ready;
  // shifting past the top bit yields zero, so an out-of-range sel grants nothing
  assign lock_gnt = (N_CH'(1) << lock_ch) & in_valid;
  assign grant = locked ? lock_gnt : mode_e'(mode) == MODE_SEL ? (N_CH'(1) << sel) & in_valid : rr_gnt;
  assign in_ready = (rst_n && ld) ? grant : '0;
  assign xfer = |in_ready;
  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_CH; i++) if (grant[i]) gidx = SW'(i);
  end
`ifdef STREAM_MUX_PKT_LOCK_EN
  lock_e st, st_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= ST_IDLE;
      lock_ch <= '0;
    end else begin
      st <= st_nx;
      if (xfer) lock_ch <= gidx;
    end
  always_comb st_nx = xfer ? (in_last[gidx] ? ST_IDLE : ST_LOCKED) : st;
  assign locked = st == ST_LOCKED;
  assign adv = mode_e'(mode) == MODE_RR && in_last[gidx];
`else
  assign locked = 1'b0;
  assign lock_ch = '0;
  assign adv = mode_e'(mode) == MODE_RR;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_ch <= '0;
      ptr <= '0;
    end else if (ld) begin
      out_valid <= xfer;
      if (xfer) begin
        out_data <= in_data[gidx*DW +: DW];
        out_last <= in_last[gidx];
        out_ch <= gidx;
        if (adv) ptr <= (gidx == SW'(N_CH - 1)) ? '0 : gidx + 1'b1;
      end
    end
endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: vector table, corner sequences and random traffic against a spec-level model
module tb_stream_mux;
  localparam logic [31:0] D = 32'hD3C2B1A0;
  localparam logic [31:0] D2 = 32'hD33CB1A0;
  logic clk = 0, rst_n = 0, mode = 0, out_ready = 0;
  logic [1:0] sel = 0, out_ch;
  logic [3:0] in_valid = 0, in_last = 0, in_ready;
  logic [31:0] in_data = 0;
  logic out_valid, out_last;
  logic [7:0] out_data;
  int n_err = 0, n_chk = 0;
  bit m_v, m_l, m_lk;
  int m_ch, m_ptr, m_lch;
  logic [7:0] m_d;
  typedef struct packed {
    logic m; logic [1:0] s; logic [3:0] v; logic [31:0] d; logic o;
    logic [3:0] rdy; logic ov; logic [7:0] od; logic [1:0] oc;
  } vec_t;
  vec_t tbl[14];
  int lock_exp[4];

  stream_mux #(.N_CH(4), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .out_ch(out_ch), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_v = 0; m_l = 0; m_d = 0; m_ch = 0; m_ptr = 0; m_lk = 0; m_lch = 0;
  endtask

  function automatic int mgrant();
    if (m_lk) return in_valid[m_lch] ? m_lch : -1;
    if (mode) return in_valid[sel] ? int'(sel) : -1;
    for (int k = 0; k < 4; k++) if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    return -1;
  endfunction

  task automatic drive(logic m, logic [1:0] s, logic [3:0] v, logic [31:0] d, logic [3:0] l, logic o);
    mode = m; sel = s; in_valid = v; in_data = d; in_last = l; out_ready = o;
  endtask

  task automatic step(string nm);
    logic [3:0] e;
    int g;
    bit ld;
    #1;
    e = '0;
    ld = !m_v || out_ready;
    g = mgrant();
    if (ld && g >= 0) e[g] = 1'b1;
    chk({nm, "_rdy"}, in_ready, e);
    @(posedge clk);
    if (ld) begin
      m_v = g >= 0;
      if (g >= 0) begin
        m_d = in_data[g*8 +: 8];
        m_l = in_last[g];
        m_ch = g;
`ifdef STREAM_MUX_PKT_LOCK_EN
        m_lk = !in_last[g];
        m_lch = g;
        if (!mode && in_last[g]) m_ptr = (g + 1) % 4;
`else
        if (!mode) m_ptr = (g + 1) % 4;
`endif
      end
    end
    #1;
    chk({nm, "_ov"}, out_valid, m_v);
    chk({nm, "_od"}, out_data, m_d);
    chk({nm, "_ol"}, out_last, m_l);
    chk({nm, "_oc"}, out_ch, m_ch);
  endtask

  initial begin
    tbl[0]  = '{0, 0, 4'hF, D,  1, 4'h2, 1, 8'hB1, 1};
    tbl[1]  = '{0, 0, 4'hF, D,  1, 4'h4, 1, 8'hC2, 2};
    tbl[2]  = '{0, 0, 4'hF, D,  1, 4'h8, 1, 8'hD3, 3};
    tbl[3]  = '{0, 0, 4'hF, D,  1, 4'h1, 1, 8'hA0, 0};
    tbl[4]  = '{1, 2, 4'hF, D2, 1, 4'h4, 1, 8'h3C, 2};
    tbl[5]  = '{1, 2, 4'hB, D2, 1, 4'h0, 0, 8'h3C, 2};
    tbl[6]  = '{1, 3, 4'h8, D,  0, 4'h8, 1, 8'hD3, 3};
    tbl[7]  = '{0, 0, 4'hF, D,  0, 4'h0, 1, 8'hD3, 3};
    tbl[8]  = '{0, 0, 4'hF, D,  0, 4'h0, 1, 8'hD3, 3};
    tbl[9]  = '{0, 0, 4'hF, D,  0, 4'h0, 1, 8'hD3, 3};
    tbl[10] = '{0, 0, 4'hF, D,  1, 4'h2, 1, 8'hB1, 1};
    tbl[11] = '{0, 0, 4'hF, D,  1, 4'h4, 1, 8'hC2, 2};
    tbl[12] = '{0, 0, 4'h0, D,  1, 4'h0, 0, 8'hC2, 2};
    tbl[13] = '{0, 0, 4'h1, D,  0, 4'h1, 1, 8'hA0, 0};
`ifdef STREAM_MUX_PKT_LOCK_EN
    lock_exp = '{1, 1, 1, 2};
`else
    lock_exp = '{1, 2, 3, 0};
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    drive(0, 0, 4'hF, D, 4'hF, 0);
    step("pre");
    step("stall");
    #2 rst_n = 0;
    #1;
    chk("rst_ov", out_valid, 0);
    chk("rst_od", out_data, 0);
    chk("rst_ol", out_last, 0);
    chk("rst_oc", out_ch, 0);
    chk("rst_rdy", in_ready, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    drive(0, 0, 4'h1, 32'h000000A5, 4'hF, 1);
    step("rel");
    chk("rel_a5", {out_valid, out_data, 6'd0, out_ch}, {1'b1, 8'hA5, 6'd0, 2'd0});
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].m, tbl[i].s, tbl[i].v, tbl[i].d, 4'hF, tbl[i].o);
      #1;
      chk($sformatf("tbl%0d_rdy", i), in_ready, tbl[i].rdy);
      step($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_out", i), {out_valid, out_data, out_ch}, {tbl[i].ov, tbl[i].od, tbl[i].oc});
    end
    for (int b = 0; b < 4; b++) begin
      drive(0, 0, 4'hF, D, (b == 0 || b == 1) ? 4'b1101 : 4'hF, 1);
      step($sformatf("lock%0d", b));
      chk($sformatf("lock%0d_ch", b), out_ch, lock_exp[b]);
    end
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), 4'($urandom), $urandom,
            4'($urandom), $urandom_range(0, 9) < 7);
      step("rnd");
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
